// File: rtl/imem_loadable.sv
// imem_loadable: instruction memory for the single-cycle RISC-V core.
//
// Serves word fetches from a byte address and is filled at run time over a
// valid/ready program-load stream. After reset the whole array is swept to
// NOP_WORD. Misaligned or out-of-range fetches are flagged and return
// NOP_WORD so the core never executes an undefined word.
//
// Optional build macro: IMEM_FETCH_REG_EN
//   defined   - inst_out, inst_valid and addr_fault are registered
//               (1-cycle fetch latency, for the pipelined core).
//   undefined - fetch path is purely combinational.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   fetch_addr    byte address from the PC
//   inst_out      fetched word, or NOP_WORD when the fetch is invalid
//   inst_valid    inst_out is a real memory word
//   addr_fault    fetch_addr is misaligned or beyond the array
//   busy          clearing or loading; the core must stall
//   ld_start      begin a load (honoured only when idle)
//   ld_valid/ld_data/ld_last/ld_ready   load beat handshake
//   ld_done       one-cycle pulse when a load terminates
//   ld_err        sticky: load filled the array without ld_last
module imem_loadable #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       inst_out,
  output logic              inst_valid,
  output logic              addr_fault,
  output logic              busy,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    StClear = 2'd0,
    StIdle  = 2'd1,
    StLoad  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            ld_done_q, ld_done_d;
  logic            ld_err_q, ld_err_d;

  logic [31:0]     mem_q [DEPTH];
  logic            mem_we;
  logic [31:0]     mem_wdata;

  logic            ptr_at_end;

  assign ptr_at_end = (ptr_q == PtrW'(DEPTH - 1));

  // ---------------------------------------------------------------------------
  // Control FSM: next state, pointer and write port
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ld_done_d = 1'b0;
    ld_err_d  = ld_err_q;
    mem_we    = 1'b0;
    mem_wdata = NOP_WORD;

    unique case (state_q)
      StClear: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_at_end) begin
          state_d = StIdle;
          ptr_d   = '0;
        end
      end

      StIdle: begin
        // ld_valid/ld_last are deliberately ignored here.
        if (ld_start) begin
          state_d  = StLoad;
          ptr_d    = '0;
          ld_err_d = 1'b0;
        end
      end

      StLoad: begin
        // ld_ready is constant 1 in this state, so ld_valid alone is a handshake.
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_wdata = ld_data;
          ptr_d     = ptr_q + 1'b1;
          if (ld_last || ptr_at_end) begin
            state_d   = StIdle;
            ptr_d     = '0;
            ld_done_d = 1'b1;
            ld_err_d  = ~ld_last;
          end
        end
      end

      default: begin
        state_d = StClear;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      ptr_q     <= '0;
      ld_done_q <= 1'b0;
      ld_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ld_done_q <= ld_done_d;
      ld_err_q  <= ld_err_d;
    end
  end

  // Storage has no reset; the post-reset sweep initialises it.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[ptr_q] <= mem_wdata;
    end
  end

  assign busy     = (state_q != StIdle);
  assign ld_ready = (state_q == StLoad);
  assign ld_done  = ld_done_q;
  assign ld_err   = ld_err_q;

  // ---------------------------------------------------------------------------
  // Fetch path
  // ---------------------------------------------------------------------------
  logic [PtrW-1:0] fetch_idx;
  logic            misaligned;
  logic            out_of_range;
  logic            fault_c;
  logic            valid_c;
  logic [31:0]     inst_c;

  assign fetch_idx  = fetch_addr[PtrW+1:2];
  assign misaligned = |fetch_addr[1:0];

  // DEPTH is a power of two, so addr >= 4*DEPTH is any bit set above the index.
  if (ADDR_W > PtrW + 2) begin : g_range_chk
    assign out_of_range = |fetch_addr[ADDR_W-1:PtrW+2];
  end else begin : g_no_range_chk
    assign out_of_range = 1'b0;
  end

  assign fault_c = misaligned | out_of_range;
  assign valid_c = ~busy & ~fault_c;
  assign inst_c  = valid_c ? mem_q[fetch_idx] : NOP_WORD;

`ifdef IMEM_FETCH_REG_EN
  logic [31:0] inst_out_q, inst_out_d;
  logic        inst_valid_q, inst_valid_d;
  logic        addr_fault_q, addr_fault_d;

  always_comb begin
    inst_out_d   = inst_c;
    inst_valid_d = valid_c;
    addr_fault_d = fault_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_out_q   <= NOP_WORD;
      inst_valid_q <= 1'b0;
      addr_fault_q <= 1'b0;
    end else begin
      inst_out_q   <= inst_out_d;
      inst_valid_q <= inst_valid_d;
      addr_fault_q <= addr_fault_d;
    end
  end

  assign inst_out   = inst_out_q;
  assign inst_valid = inst_valid_q;
  assign addr_fault = addr_fault_q;
`else
  assign inst_out   = inst_c;
  assign inst_valid = valid_c;
  assign addr_fault = fault_c;
`endif

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable (default build, combinational fetch).
// Reference model: an array of words plus a busy flag, updated from the
// load/clear rules; fetch responses derived from address arithmetic.
module tb_imem_loadable;

  localparam int unsigned Depth = 64;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_addr;
  logic [31:0] inst_out;
  logic        inst_valid;
  logic        addr_fault;
  logic        busy;
  logic        ld_start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_done;
  logic        ld_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_mem [Depth];
  bit          model_busy;

  imem_loadable dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_addr (fetch_addr),
    .inst_out   (inst_out),
    .inst_valid (inst_valid),
    .addr_fault (addr_fault),
    .busy       (busy),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .ld_err     (ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < Depth; i++) model_mem[i] = Nop;
  endtask

  // Presents addr for one cycle and checks the fetch response mid-cycle.
  task automatic check_fetch(input logic [31:0] addr);
    bit          exp_fault;
    bit          exp_valid;
    logic [31:0] exp_out;
    logic [5:0]  idx;
    fetch_addr = addr;
    @(negedge clk);
    idx       = addr[7:2];
    exp_fault = (addr[1:0] != 2'b00) || (addr >= 4 * Depth);
    exp_valid = !model_busy && !exp_fault;
    exp_out   = exp_valid ? model_mem[idx] : Nop;
    checks++;
    if (addr_fault !== exp_fault) begin
      failures++;
      $display("FAIL addr_fault @%h: got %b expected %b", addr, addr_fault, exp_fault);
    end
    checks++;
    if (inst_valid !== exp_valid) begin
      failures++;
      $display("FAIL inst_valid @%h: got %b expected %b", addr, inst_valid, exp_valid);
    end
    checks++;
    if (inst_out !== exp_out) begin
      failures++;
      $display("FAIL inst_out @%h: got %h expected %h", addr, inst_out, exp_out);
    end
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle after rst falls; expects DEPTH busy cycles.
  task automatic check_sweep();
    model_busy = 1'b1;
    fetch_addr = 32'h0;
    for (int i = 0; i < Depth; i++) begin
      checks++;
      if (busy !== 1'b1 || inst_valid !== 1'b0 || inst_out !== Nop) begin
        failures++;
        $display("FAIL sweep cycle %0d: busy=%b valid=%b out=%h expected busy=1 valid=0 out=%h",
                 i + 1, busy, inst_valid, inst_out, Nop);
      end
      step();
    end
    checks++;
    if (busy !== 1'b0 || inst_valid !== 1'b1 || inst_out !== Nop) begin
      failures++;
      $display("FAIL sweep end: busy=%b valid=%b out=%h expected busy=0 valid=1 out=%h",
               busy, inst_valid, inst_out, Nop);
    end
    model_busy = 1'b0;
    model_clear();
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (busy !== 1'b1 || ld_ready !== 1'b0 || ld_done !== 1'b0 || ld_err !== 1'b0 ||
        inst_valid !== 1'b0 || inst_out !== Nop) begin
      failures++;
      $display("FAIL %s: busy=%b rdy=%b done=%b err=%b valid=%b out=%h expected 1 0 0 0 0 %h",
               name, busy, ld_ready, ld_done, ld_err, inst_valid, inst_out, Nop);
    end
  endtask

  // Runs one load of the given words; optional random idle gaps and ignored ld_start.
  task automatic run_load(input logic [31:0] words[$], input bit use_last, input bit noisy);
    int n;
    n = words.size();
    ld_start = 1'b1;
    step();
    ld_start   = 1'b0;
    model_busy = 1'b1;
    checks++;
    if (busy !== 1'b1 || ld_ready !== 1'b1 || ld_err !== 1'b0) begin
      failures++;
      $display("FAIL load start: busy=%b rdy=%b err=%b expected 1 1 0", busy, ld_ready, ld_err);
    end
    for (int i = 0; i < n; i++) begin
      if (noisy) begin
        repeat ($urandom_range(0, 2)) begin
          ld_valid = 1'b0;
          ld_data  = $urandom;
          ld_last  = 1'($urandom_range(0, 1));
          ld_start = 1'($urandom_range(0, 1));
          step();
        end
      end
      checks++;
      if (ld_ready !== 1'b1 || busy !== 1'b1 || ld_done !== 1'b0) begin
        failures++;
        $display("FAIL beat %0d ready: rdy=%b busy=%b done=%b expected 1 1 0",
                 i, ld_ready, busy, ld_done);
      end
      ld_valid = 1'b1;
      ld_data  = words[i];
      ld_last  = use_last && (i == n - 1);
      ld_start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      model_mem[i] = words[i];
      step();
    end
    ld_valid   = 1'b0;
    ld_last    = 1'b0;
    ld_start   = 1'b0;
    model_busy = 1'b0;
    checks++;
    if (busy !== 1'b0 || ld_done !== 1'b1 || ld_ready !== 1'b0 || ld_err !== !use_last) begin
      failures++;
      $display("FAIL load end: busy=%b done=%b rdy=%b err=%b expected 0 1 0 %b",
               busy, ld_done, ld_ready, ld_err, !use_last);
    end
    step();
    checks++;
    if (ld_done !== 1'b0 || ld_err !== !use_last) begin
      failures++;
      $display("FAIL done pulse width: done=%b err=%b expected 0 %b", ld_done, ld_err, !use_last);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    fetch_addr = 32'h6;
    ld_start   = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    ld_last    = 1'b0;
    model_busy = 1'b1;
    model_clear();
    step();
    step();
    check_reset_values("reset hold");
    checks++;
    if (addr_fault !== 1'b1) begin
      failures++;
      $display("FAIL reset addr_fault@6: got %b expected 1", addr_fault);
    end
    fetch_addr = 32'h0;
    #1;
    checks++;
    if (addr_fault !== 1'b0) begin
      failures++;
      $display("FAIL reset addr_fault@0: got %b expected 0", addr_fault);
    end
    rst = 1'b0;
    check_reset_values("reset first cycle");
    check_sweep();
  endtask

  task automatic test_directed_load();
    logic [31:0] w[$];
    w = '{32'h0000_0000, 32'h0198_06B3, 32'h4034_02B3};
    run_load(w, 1'b1, 1'b0);
    check_fetch(32'h4);
    checks++;
    if (inst_out !== 32'h0198_06B3 && inst_valid === 1'b1) begin
      failures++;
      $display("FAIL directed word1: got %h expected 019806b3", inst_out);
    end
    check_fetch(32'h8);
    check_fetch(32'hC);
    check_fetch(32'h0);
  endtask

  task automatic test_faults();
    check_fetch(32'h6);
    check_fetch(32'h100);
    check_fetch(32'h1);
    check_fetch(32'hFFFF_FFFC);
    check_fetch(32'h0000_0103);
    check_fetch(32'hFC);
    for (int i = 0; i < 10; i++) check_fetch($urandom);
  endtask

  task automatic test_idle_ignored();
    ld_valid = 1'b1;
    ld_last  = 1'b1;
    repeat (4) begin
      ld_data = $urandom;
      step();
      checks++;
      if (busy !== 1'b0 || ld_done !== 1'b0 || ld_ready !== 1'b0) begin
        failures++;
        $display("FAIL idle beat: busy=%b done=%b rdy=%b expected 0 0 0", busy, ld_done, ld_ready);
      end
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    for (int a = 0; a < 16; a++) check_fetch(32'(a * 4));
  endtask

  task automatic test_overflow();
    logic [31:0] w[$];
    for (int i = 0; i < Depth; i++) w.push_back($urandom);
    run_load(w, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) check_fetch(32'($urandom_range(0, Depth - 1) * 4));
    check_fetch(32'hFC);
    // Short load clears ld_err at start and keeps the older words beyond it.
    w = '{32'h0094_8663};
    run_load(w, 1'b1, 1'b0);
    check_fetch(32'h0);
    check_fetch(32'h4);
  endtask

  task automatic test_random_loads();
    logic [31:0] w[$];
    for (int t = 0; t < 6; t++) begin
      w.delete();
      repeat ($urandom_range(1, 20)) w.push_back($urandom);
      run_load(w, 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) begin
        if ($urandom_range(0, 3) == 0) check_fetch($urandom);
        else check_fetch(32'($urandom_range(0, 4 * Depth - 1)));
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] w[$];
    // Leave ld_err set, then check a reset in IDLE clears it.
    for (int i = 0; i < Depth; i++) w.push_back($urandom);
    run_load(w, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_values("reset from idle");
    check_sweep();
    // Now interrupt a load after two beats.
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data  = $urandom;
      step();
    end
    ld_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    check_reset_values("reset mid-load");
    check_sweep();
    for (int a = 0; a < Depth; a++) check_fetch(32'(a * 4));
  endtask

  initial begin
    test_reset();
    test_directed_load();
    test_faults();
    test_idle_ignored();
    test_overflow();
    test_random_loads();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised instruction memory for the single-cycle RISC-V core. It serves combinational word fetches from a byte address, and it is filled at run time through a valid/ready program-load stream instead of hard-coded contents. After reset it sweeps the whole array to the canonical NOP. It also flags misaligned and out-of-range fetches so the core never executes undefined words.

## Interface
- DEPTH, 64: number of 32-bit instruction words; power of two, at least 4.
- ADDR_W, 32: fetch address width, in bytes.
- NOP_WORD, 32'h0000_0013: fill and substitute value (addi x0,x0,0).
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- fetch_addr  in  ADDR_W  byte address from the PC.
- inst_out  out  32  fetched instruction, or NOP_WORD when the fetch is invalid.
- inst_valid  out  1  inst_out is a real memory word.
- addr_fault  out  1  fetch_addr is misaligned or out of range.
- busy  out  1  the memory is in CLEAR or LOAD; the core must stall.
- ld_start  in  1  request to begin a load; sampled only in IDLE.
- ld_valid  in  1  ld_data beat is present.
- ld_data  in  32  instruction word to write.
- ld_last  in  1  the current beat is the final word.
- ld_ready  out  1  a beat is accepted this cycle when ld_valid is also high.
- ld_done  out  1  one-cycle pulse when a load terminates.
- ld_err  out  1  sticky; the load hit DEPTH words without ld_last.

## Operation
- FSM states: CLEAR, IDLE, LOAD. Word pointer ptr is log2(DEPTH) bits wide.
- CLEAR:
  - Writes NOP_WORD to mem[ptr] and increments ptr each cycle.
  - After writing word DEPTH-1, goes to IDLE with ptr=0.
  - Takes exactly DEPTH cycles after rst deasserts.
- IDLE:
  - ld_start=1 moves the FSM to LOAD, sets ptr=0 and clears ld_err.
  - ld_valid and ld_last are ignored in IDLE.
- LOAD, with ld_ready=1:
  - Each handshake (ld_valid & ld_ready) writes ld_data to mem[ptr] and increments ptr.
  - If the beat carries ld_last, or ptr==DEPTH-1, the FSM goes to IDLE in the next cycle and pulses ld_done.
  - A full terminate without ld_last also sets ld_err.
  - A beat arriving when ld_ready=0 is not written and must be held by the source.
  - ld_start during LOAD or CLEAR is ignored.
- Words not written by a load keep their previous contents: NOP_WORD after a clear, otherwise the older program.
- Fetch:
  - Word index = fetch_addr[log2(DEPTH)+1:2].
  - addr_fault = (fetch_addr[1:0] != 0) | (fetch_addr >= 4*DEPTH). It is combinational and independent of FSM state.
  - inst_valid = !busy & !addr_fault.
  - inst_out = inst_valid ? mem[index] : NOP_WORD.
- busy = (state != IDLE).
- rst asserted during any state, including mid-LOAD:
  - Forces CLEAR with ptr=0 and clears ld_err.
  - The partial load is discarded by the sweep.

## Timing
- Reset values while rst=1 and in the first cycle after:
  - state=CLEAR, busy=1, ld_ready=0, ld_done=0, ld_err=0.
  - inst_valid=0, inst_out=NOP_WORD.
  - addr_fault follows fetch_addr.
- Fetch latency is 0 cycles (combinational) unless IMEM_FETCH_REG_EN is defined.
- A word written on edge N is readable by a fetch in cycle N+1. busy is already 0 in that cycle if this was the final beat.
- ld_done is high for exactly the one cycle in which state first reads IDLE after LOAD.
- ld_ready is a function of state only: no combinational path from ld_valid to ld_ready.

## Configuration
- IMEM_FETCH_REG_EN defined:
  - inst_out, inst_valid and addr_fault are registered, giving a 1-cycle fetch latency.
  - These registers reset to NOP_WORD/0/0.
  - This mode is for the pipelined core.
- IMEM_FETCH_REG_EN undefined: the fetch path is purely combinational, as described above.

## Test plan
- Release rst, then hold fetch_addr=0x0 -> busy=1 for 64 cycles; next cycle busy=0, inst_valid=1, inst_out=0x00000013.
- ld_start, then beats 0x00000000, 0x019806B3, 0x403402B3 with ld_last on the third -> ld_done pulse; fetches at 0x4/0x8 return 0x019806B3/0x403402B3; 0xC returns 0x00000013.
- fetch_addr=0x6 -> addr_fault=1, inst_valid=0, inst_out=0x00000013. fetch_addr=0x100 with DEPTH=64 -> same response.
- Load 64 beats with no ld_last -> ld_ready drops after beat 64, ld_done pulses, ld_err=1; a later ld_start clears ld_err.
- Assert rst after 2 beats of a load -> busy=1 for 64 cycles; every address then reads 0x00000013.
- With IMEM_FETCH_REG_EN, after loading 0x00948663 at 0x2C and setting fetch_addr=0x2C at edge N -> inst_out=0x00948663 after edge N+1.
